// File: rtl/vrp_rr_arb.sv
// Round-robin valid/ready arbiter merging WIDTH requesters onto one registered master channel, tagging beats with source index.
// Latency: one cycle; a beat accepted at a rising edge is presented on vld_m/pld_m right after that edge.
// Backpressure: v_rdy_s follows rdy_m combinationally through load = !vld_m || rdy_m; packet locking under VRP_RR_ARB_PKT_LOCK_EN.
module vrp_rr_arb #(
  parameter int WIDTH     = 8,
  parameter int PLD_WIDTH = 32,
  parameter int IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     v_vld_s,
  input  logic [PLD_WIDTH-1:0] v_pld_s [WIDTH-1:0],
  input  logic [WIDTH-1:0]     v_last_s,
  output logic [WIDTH-1:0]     v_rdy_s,
  output logic                 vld_m,
  output logic [PLD_WIDTH-1:0] pld_m,
  output logic                 last_m,
  output logic [IDX_WIDTH-1:0] src_m,
  input  logic                 rdy_m
);

  // Round-robin pointer: index searched first on the next arbitration.
  logic [IDX_WIDTH-1:0] ptr;

  // Unlocked search result.
  logic                 rr_vld;
  logic [IDX_WIDTH-1:0] rr_idx;
  int                   cand;

  // Final selection after the lock restriction is applied.
  logic                 sel_vld;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic                 sel_last;

  // Output register may take a new beat when empty or being drained.
  logic load;
  // A requester handshake happens this cycle.
  logic acc;

  assign load = !vld_m || rdy_m;
  assign acc  = load && sel_vld && rst_n;

  // Rotating search from ptr; walking offsets high-to-low lets the smallest offset win.
  // Wrap is an explicit subtract so non-power-of-2 WIDTH never yields an index >= WIDTH.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= WIDTH) begin
        cand = cand - WIDTH;
      end
      if (v_vld_s[cand]) begin
        rr_vld = 1'b1;
        rr_idx = IDX_WIDTH'(cand);
      end
    end
  end

`ifdef VRP_RR_ARB_PKT_LOCK_EN

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  lock_state_t          state_q;
  lock_state_t          state_d;
  logic [IDX_WIDTH-1:0] lock_idx_q;
  logic [IDX_WIDTH-1:0] lock_idx_d;

  // While a packet is open only its owner may be granted; a gap from the owner is held as a bubble.
  always_comb begin
    sel_vld = rr_vld;
    sel_idx = rr_idx;
    if (state_q == LOCKED) begin
      sel_vld = v_vld_s[lock_idx_q];
      sel_idx = lock_idx_q;
    end
    sel_last = v_last_s[sel_idx];
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Enter LOCKED on a non-final beat, leave it on the owner's final beat; single-beat packets stay IDLE.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      IDLE: begin
        if (acc && !sel_last) begin
          state_d    = LOCKED;
          lock_idx_d = sel_idx;
        end
      end
      LOCKED: begin
        if (acc && sel_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`else

  // Every beat is its own packet; v_last_s is intentionally left unconnected to logic.
  logic last_unused;
  assign last_unused = ^v_last_s;

  assign sel_vld  = rr_vld;
  assign sel_idx  = rr_idx;
  assign sel_last = 1'b1;

`endif

  // Ready goes only to the selected requester and only when the output register can load.
  always_comb begin
    v_rdy_s = '0;
    if (acc) begin
      v_rdy_s[sel_idx] = 1'b1;
    end
  end

  // Advance past the winner at packet end with compare-and-wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (acc && sel_last) begin
      ptr <= (sel_idx == IDX_WIDTH'(WIDTH - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  // Single-entry output register; data fields only change when a beat is actually loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_m  <= 1'b0;
      pld_m  <= '0;
      last_m <= 1'b0;
      src_m  <= '0;
    end else if (load) begin
      vld_m <= acc;
      if (acc) begin
        pld_m  <= v_pld_s[sel_idx];
        last_m <= sel_last;
        src_m  <= sel_idx;
      end
    end
  end

  // At most one requester sees ready in any cycle.
  a_rdy_onehot: assert property (@(posedge clk) $onehot0(v_rdy_s));

  // A stalled beat must not change under the consumer.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (vld_m && !rdy_m) |=> (vld_m && $stable(pld_m) && $stable(src_m) && $stable(last_m)));

endmodule
